// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache with miss FSM
module dcache_ctrl #(
    parameter int LINES  = 32,
    parameter int LINE_W = 256,
    parameter int IDX_W  = $clog2(LINES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);
    localparam int TAG_W = 27 - IDX_W;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
    state_t state_q, state_d;
    logic [LINE_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [LINES-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        word;
    logic              hit, miss, store_hit, fill, unused_addr;
    assign tag         = p1_addr_i[31:5+IDX_W];
    assign idx         = p1_addr_i[4+IDX_W:5];
    assign word        = p1_addr_i[4:2];
    assign unused_addr = ^p1_addr_i[1:0];
    assign hit         = valid_q[idx] && tag_q[idx] == tag;
    assign miss        = state_q == IDLE && p1_req_i && !hit;
    assign store_hit   = state_q == IDLE && p1_req_i && p1_write_i && hit;
    assign fill        = state_q == ALLOCATE && mem_ack_i;
    assign p1_stall_o  = rst_i && (state_q != IDLE || miss);
    assign p1_data_o   = rst_i ? data_q[idx][{word, 5'd0} +: 32] : '0;
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            IDLE: if (miss) state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[req_idx_q], req_idx_q, 5'b0};
                mem_data_o   = data_q[req_idx_q];
                if (mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag_q, req_idx_q, 5'b0};
                if (mem_ack_i) state_d = REFILL;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end else if (fill) begin
            valid_q[req_idx_q] <= 1'b1;
            dirty_q[req_idx_q] <= 1'b0;
        end
    end
    // storage arrays carry no reset; valid bits qualify their contents
    always_ff @(posedge clk_i) begin
        if (miss) begin
            req_tag_q <= tag;
            req_idx_q <= idx;
        end
        if (store_hit) data_q[idx][{word, 5'd0} +: 32] <= p1_data_i;
        if (fill) begin
            data_q[req_idx_q] <= mem_data_i;
            tag_q[req_idx_q]  <= req_tag_q;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed checks of hits, clean/dirty misses, spurious acks and reset
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         p1_req_i = 1'b0, p1_write_i = 1'b0;
    logic [31:0]  p1_addr_i = '0, p1_data_i = '0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i = 1'b0;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i = '0;
    int           total = 0, bad = 0;
    int           stalls, n_wb, n_al;
    logic         en_done;
    logic [31:0]  wb_addr, al_addr, rdata;
    logic [255:0] wb_line;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", t, got, exp);
        end
    endtask

    // one pipeline access; memory acks on cycle wl of WRITEBACK and ll of ALLOCATE
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] base, input int wl, input int ll, input logic spur);
        logic done;
        p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
        for (int k = 0; k < 8; k++) mem_data_i[k*32 +: 32] = base + k;
        stalls = 0; n_wb = 0; n_al = 0; done = 1'b0; en_done = 1'b0;
        wb_addr = '0; al_addr = '0; wb_line = '0; rdata = '0;
        for (int n = 0; n < 100 && !done; n++) begin
            mem_ack_i = 1'b0;
            #1;
            if (!p1_stall_o) begin
                done = 1'b1;
                rdata = p1_data_o;
                en_done = mem_enable_o;
            end else begin
                stalls++;
                if (mem_enable_o && mem_write_o) begin
                    n_wb++; wb_addr = mem_addr_o; wb_line = mem_data_o;
                    mem_ack_i = (n_wb == wl);
                end else if (mem_enable_o) begin
                    n_al++; al_addr = mem_addr_o;
                    mem_ack_i = (n_al == ll);
                end else begin
                    mem_ack_i = spur;
                end
            end
            @(negedge clk_i);
        end
        p1_req_i = 1'b0; mem_ack_i = 1'b0;
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        p1_req_i = 1'b1; p1_addr_i = 32'h40;
        @(negedge clk_i); #1;
        check("rst_stall", {31'd0, p1_stall_o}, 32'd0);
        check("rst_data", p1_data_o, 32'd0);
        check("rst_en", {31'd0, mem_enable_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1; p1_req_i = 1'b0;
        @(negedge clk_i);

        access(1'b0, 32'h40, 32'h0, 32'h100, 0, 4, 1'b0);
        check("m1_stall", stalls, 32'd6);
        check("m1_al_cyc", n_al, 32'd4);
        check("m1_wb_cyc", n_wb, 32'd0);
        check("m1_al_addr", al_addr, 32'h40);
        check("m1_data", rdata, 32'h100);
        check("m1_en_done", {31'd0, en_done}, 32'd0);

        access(1'b0, 32'h44, 32'h0, 32'h0, 0, 1, 1'b0);
        check("h1_stall", stalls, 32'd0);
        check("h1_data", rdata, 32'h101);
        check("h1_en", {31'd0, en_done}, 32'd0);

        access(1'b1, 32'h48, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0);
        check("sh_stall", stalls, 32'd0);

        access(1'b0, 32'h448, 32'h0, 32'h200, 2, 3, 1'b0);
        check("d1_stall", stalls, 32'd7);
        check("d1_wb_cyc", n_wb, 32'd2);
        check("d1_al_cyc", n_al, 32'd3);
        check("d1_wb_addr", wb_addr, 32'h40);
        check("d1_wb_w2", wb_line[95:64], 32'hDEADBEEF);
        check("d1_wb_w0", wb_line[31:0], 32'h100);
        check("d1_al_addr", al_addr, 32'h440);
        check("d1_data", rdata, 32'h202);

        mem_data_i = {8{32'hBAD0BAD0}};
        mem_ack_i = 1'b1; #1;
        check("ia_en", {31'd0, mem_enable_o}, 32'd0);
        @(negedge clk_i); mem_ack_i = 1'b0; #1;
        check("ia_en2", {31'd0, mem_enable_o}, 32'd0);
        check("ia_stall", {31'd0, p1_stall_o}, 32'd0);
        @(negedge clk_i);
        access(1'b0, 32'h448, 32'h0, 32'h0, 0, 1, 1'b0);
        check("ia_hit_stall", stalls, 32'd0);
        check("ia_hit_data", rdata, 32'h202);

        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h44; #1;
        check("rs_miss", {31'd0, p1_stall_o}, 32'd1);
        @(negedge clk_i); #1;
        check("rs_al1", {31'd0, mem_enable_o}, 32'd1);
        @(negedge clk_i); rst_i = 1'b0; #1;
        check("rs_low_stall", {31'd0, p1_stall_o}, 32'd0);
        check("rs_low_data", p1_data_o, 32'd0);
        @(negedge clk_i); rst_i = 1'b1; p1_req_i = 1'b0; #1;
        check("rs_en", {31'd0, mem_enable_o}, 32'd0);
        check("rs_stall", {31'd0, p1_stall_o}, 32'd0);
        mem_ack_i = 1'b1;
        @(negedge clk_i); mem_ack_i = 1'b0; #1;
        check("rs_late_ack", {31'd0, mem_enable_o}, 32'd0);
        @(negedge clk_i);
        access(1'b0, 32'h44, 32'h0, 32'h500, 0, 1, 1'b0);
        check("rs_re_stall", stalls, 32'd3);
        check("rs_re_data", rdata, 32'h501);

        access(1'b1, 32'h80, 32'h12345678, 32'h300, 0, 2, 1'b1);
        check("sm_stall", stalls, 32'd4);
        check("sm_al_addr", al_addr, 32'h80);
        check("sm_wb_cyc", n_wb, 32'd0);
        access(1'b0, 32'h80, 32'h0, 32'h0, 0, 1, 1'b0);
        check("sm_rd0", rdata, 32'h12345678);
        check("sm_rd0_stall", stalls, 32'd0);
        access(1'b0, 32'h84, 32'h0, 32'h0, 0, 1, 1'b0);
        check("sm_rd1", rdata, 32'h301);

        access(1'b0, 32'h480, 32'h0, 32'h400, 1, 1, 1'b0);
        check("d2_stall", stalls, 32'd4);
        check("d2_wb_addr", wb_addr, 32'h80);
        check("d2_wb_w0", wb_line[31:0], 32'h12345678);
        check("d2_wb_w1", wb_line[63:32], 32'h301);
        check("d2_al_addr", al_addr, 32'h480);
        check("d2_data", rdata, 32'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
